// File: rtl/term_pkg.sv
// Shared constants and state type for the terminal write controller.
// Backspace handling is enabled by defining TERM_BACKSPACE_EN.
package term_pkg;

  localparam int COLS_DEF = 40;
  localparam int ROWS_DEF = 24;

  localparam logic [5:0]  SPACE_CODE = 6'd32;
  localparam logic [11:0] CLR_WORDS  = 12'd2048;

  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_DEL   = 8'h7F;
  localparam logic [7:0] CH_BS_HI = 8'h88;
  localparam logic [7:0] CH_CR_HI = 8'h8D;
  localparam logic [7:0] CH_CSI   = 8'h9B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUT,
    S_NEWLINE,
    S_SCROLL,
    S_CLEAR
  } state_t;

  function automatic logic [4:0] row_dist(
    input logic [4:0] r,
    input logic [4:0] s
  );
    return r - s;
  endfunction

endpackage

// File: rtl/term_write_ctrl_if.sv
// Character handshake and VRAM write bus of the terminal controller.
// Build option TERM_BACKSPACE_EN is handled in the controller.
interface term_write_ctrl_if;

  logic        chr_valid;
  logic [7:0]  chr_data;
  logic        chr_ready;
  logic        vram_w_en;
  logic [10:0] vram_w_addr;
  logic [5:0]  vram_din;

  modport slave (
    input  chr_valid,
    input  chr_data,
    output chr_ready,
    output vram_w_en,
    output vram_w_addr,
    output vram_din
  );

  modport master (
    output chr_valid,
    output chr_data,
    input  chr_ready,
    input  vram_w_en,
    input  vram_w_addr,
    input  vram_din
  );

endinterface

// File: rtl/term_write_ctrl_vram_fill.sv
// Sequential VRAM sweep: one write per cycle from base for count words.
// Used for row scroll and full-screen clear (TERM_BACKSPACE_EN unused here).
module vram_fill (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] base,
  input  logic [11:0] count,
  output logic        busy,
  output logic        done,
  output logic [10:0] addr
);

  logic [11:0] rem_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      addr  <= '0;
      rem_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      addr  <= base;
      rem_q <= count - 12'd1;
    end else if (busy) begin
      if (rem_q == '0) begin
        busy <= 1'b0;
      end else begin
        addr  <= addr + 11'd1;
        rem_q <= rem_q - 12'd1;
      end
    end
  end

  assign done = busy && (rem_q == '0);

endmodule

// File: rtl/term_write_ctrl.sv
// Terminal write controller: CPU characters to glyph writes in ring VRAM.
// Define TERM_BACKSPACE_EN to make 0x08/0x88 erase the previous cell.
module term_write_ctrl
  import term_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  term_write_ctrl_if.slave    bus,
  output logic [4:0]          cursor_row,
  output logic [5:0]          cursor_col,
  output logic [4:0]          start_row,
  output logic                busy
);

  localparam logic [5:0]  COL_MAX = 6'(COLS - 1);
  localparam logic [4:0]  ROWS5   = 5'(ROWS);
  localparam logic [11:0] COLS12  = 12'(COLS);

  state_t      state_q, state_n;
  logic [4:0]  row_q, row_n, start_q, start_n;
  logic [5:0]  col_q, col_n;
  logic        pend_q, pend_n;
  logic        bs_q, bs_n;
  logic        busy_q;
  logic        pw_q, pw_n;
  logic [10:0] pa_q, pa_n;
  logic [5:0]  pd_q, pd_n;

  logic        fill_start;
  logic [10:0] fill_base;
  logic [11:0] fill_cnt;
  logic        fill_busy, fill_done;
  logic [10:0] fill_addr;

  logic        take, is_cr, is_drop, is_bs;
  logic [4:0]  nrow;

  assign bus.chr_ready = rst_n & (state_q == S_IDLE)
                       & ~clr_req & ~pend_q;
  assign take = bus.chr_valid & bus.chr_ready;

  assign is_cr   = (bus.chr_data == CH_CR)
                 | (bus.chr_data == CH_CR_HI);
  assign is_drop = (bus.chr_data == CH_NUL)
                 | (bus.chr_data == CH_LF)
                 | (bus.chr_data == CH_DEL)
                 | (bus.chr_data == CH_CSI);
`ifdef TERM_BACKSPACE_EN
  assign is_bs   = (bus.chr_data == CH_BS)
                 | (bus.chr_data == CH_BS_HI);
`else
  assign is_bs   = 1'b0;
`endif

  assign nrow = row_q + 5'd1;

  always_comb begin
    state_n    = state_q;
    row_n      = row_q;
    col_n      = col_q;
    start_n    = start_q;
    pend_n     = pend_q;
    bs_n       = bs_q;
    pw_n       = 1'b0;
    pa_n       = pa_q;
    pd_n       = pd_q;
    fill_start = 1'b0;
    fill_base  = '0;
    fill_cnt   = '0;

    // a clear arriving mid-operation waits for the next IDLE
    if (clr_req && (state_q == S_PUT || state_q == S_NEWLINE
                    || state_q == S_SCROLL))
      pend_n = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (clr_req || pend_q) begin
          state_n    = S_CLEAR;
          row_n      = '0;
          col_n      = '0;
          start_n    = '0;
          pend_n     = 1'b0;
          fill_start = 1'b1;
          fill_cnt   = CLR_WORDS;
        end else if (take) begin
          unique case (1'b1)
            is_cr: begin
              col_n   = '0;
              state_n = S_NEWLINE;
            end
            is_drop: ;
            is_bs: begin
              if (col_q != '0) begin
                col_n   = col_q - 6'd1;
                pw_n    = 1'b1;
                pa_n    = {row_q, col_q - 6'd1};
                pd_n    = SPACE_CODE;
                bs_n    = 1'b1;
                state_n = S_PUT;
              end
            end
            default: begin
              pw_n    = 1'b1;
              pa_n    = {row_q, col_q};
              pd_n    = {~bus.chr_data[6], bus.chr_data[4:0]};
              bs_n    = 1'b0;
              state_n = S_PUT;
            end
          endcase
        end
      end
      S_PUT: begin
        if (bs_q) begin
          state_n = S_IDLE;
        end else if (col_q == COL_MAX) begin
          col_n   = '0;
          state_n = S_NEWLINE;
        end else begin
          col_n   = col_q + 6'd1;
          state_n = S_IDLE;
        end
      end
      S_NEWLINE: begin
        row_n = nrow;
        if (row_dist(nrow, start_q) == ROWS5) begin
          start_n    = start_q + 5'd1;
          fill_start = 1'b1;
          fill_base  = {nrow, 6'd0};
          fill_cnt   = COLS12;
          state_n    = S_SCROLL;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SCROLL: if (fill_done) state_n = S_IDLE;
      S_CLEAR:  if (fill_done) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      start_q <= '0;
      pend_q  <= 1'b0;
      bs_q    <= 1'b0;
      busy_q  <= 1'b0;
      pw_q    <= 1'b0;
      pa_q    <= '0;
      pd_q    <= '0;
    end else begin
      state_q <= state_n;
      row_q   <= row_n;
      col_q   <= col_n;
      start_q <= start_n;
      pend_q  <= pend_n;
      bs_q    <= bs_n;
      busy_q  <= (state_n != S_IDLE);
      pw_q    <= pw_n;
      pa_q    <= pa_n;
      pd_q    <= pd_n;
    end
  end

  vram_fill u_fill (
    .clk   (clk),
    .rst_n (rst_n),
    .start (fill_start),
    .base  (fill_base),
    .count (fill_cnt),
    .busy  (fill_busy),
    .done  (fill_done),
    .addr  (fill_addr)
  );

  assign bus.vram_w_en   = pw_q | fill_busy;
  assign bus.vram_w_addr = fill_busy ? fill_addr : pa_q;
  assign bus.vram_din    = fill_busy ? SPACE_CODE : pd_q;

  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign start_row  = start_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_term_write_ctrl.sv
// Directed bench for term_write_ctrl; honours TERM_BACKSPACE_EN.
// Table vectors for single characters plus hand sequences for sweeps.
module tb_term_write_ctrl;

  logic       clk;
  logic       rst_n;
  logic       clr_req;
  logic [4:0] cursor_row;
  logic [5:0] cursor_col;
  logic [4:0] start_row;
  logic       busy;

  term_write_ctrl_if bus();

  term_write_ctrl #(.COLS(40), .ROWS(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (clr_req),
    .bus        (bus),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .start_row  (start_row),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] a;
    logic [5:0]  d;
  } wr_t;

  wr_t wq[$];

  always @(posedge clk)
    if (bus.vram_w_en) wq.push_back({bus.vram_w_addr, bus.vram_din});

  typedef struct {
    logic [7:0]  ch;
    logic [4:0]  row;
    logic [5:0]  col;
    int          nw;
    logic [10:0] addr;
    logic [5:0]  din;
  } vec_t;

  vec_t vt[15];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input int lim, input string nm);
    int n;
    n = 0;
    while (!bus.chr_ready && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 32'(bus.chr_ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] c);
    wait_ready(100, "send_ready");
    bus.chr_valid = 1'b1;
    bus.chr_data  = c;
    @(posedge clk); #1;
    bus.chr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    clr_req       = 1'b0;
    bus.chr_valid = 1'b0;
    bus.chr_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;

    vt[0]  = '{8'hC1, 5'd0, 6'd1, 1, 11'h000, 6'h01};
    vt[1]  = '{8'h0A, 5'd0, 6'd1, 0, 11'h000, 6'h00};
    vt[2]  = '{8'h7F, 5'd0, 6'd1, 0, 11'h000, 6'h00};
    vt[3]  = '{8'h00, 5'd0, 6'd1, 0, 11'h000, 6'h00};
    vt[4]  = '{8'h9B, 5'd0, 6'd1, 0, 11'h000, 6'h00};
    vt[5]  = '{8'h41, 5'd0, 6'd2, 1, 11'h001, 6'h01};
    vt[6]  = '{8'h30, 5'd0, 6'd3, 1, 11'h002, 6'h30};
`ifdef TERM_BACKSPACE_EN
    vt[7]  = '{8'h88, 5'd0, 6'd2, 1, 11'h002, 6'h20};
`else
    vt[7]  = '{8'h88, 5'd0, 6'd4, 1, 11'h003, 6'h28};
`endif
    vt[8]  = '{8'h0D, 5'd1, 6'd0, 0, 11'h000, 6'h00};
    vt[9]  = '{8'h8D, 5'd2, 6'd0, 0, 11'h000, 6'h00};
    vt[10] = '{8'h5A, 5'd2, 6'd1, 1, 11'h080, 6'h1A};
    vt[11] = '{8'hFF, 5'd2, 6'd2, 1, 11'h081, 6'h1F};
`ifdef TERM_BACKSPACE_EN
    vt[12] = '{8'h08, 5'd2, 6'd1, 1, 11'h081, 6'h20};
    vt[13] = '{8'h0D, 5'd3, 6'd0, 0, 11'h000, 6'h00};
    vt[14] = '{8'h88, 5'd3, 6'd0, 0, 11'h000, 6'h00};
`else
    vt[12] = '{8'h08, 5'd2, 6'd3, 1, 11'h082, 6'h28};
    vt[13] = '{8'h0D, 5'd3, 6'd0, 0, 11'h000, 6'h00};
    vt[14] = '{8'h88, 5'd3, 6'd1, 1, 11'h0C0, 6'h28};
`endif

    // reset values, sampled while rst_n is still low
    rst_n         = 1'b0;
    clr_req       = 1'b0;
    bus.chr_valid = 1'b0;
    bus.chr_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.chr_ready), 0);
    chk("rst_wen",   32'(bus.vram_w_en), 0);
    chk("rst_addr",  32'(bus.vram_w_addr), 0);
    chk("rst_din",   32'(bus.vram_din), 0);
    chk("rst_row",   32'(cursor_row), 0);
    chk("rst_col",   32'(cursor_col), 0);
    chk("rst_start", 32'(start_row), 0);
    chk("rst_busy",  32'(busy), 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.chr_ready), 1);

    // single 0xC1: write during PUT, ready two cycles after accept
    do_reset();
    send(8'hC1);
    chk("c1_ready_put", 32'(bus.chr_ready), 0);
    chk("c1_busy_put",  32'(busy), 1);
    chk("c1_wen",       32'(bus.vram_w_en), 1);
    chk("c1_addr",      32'(bus.vram_w_addr), 0);
    chk("c1_din",       32'(bus.vram_din), 32'h01);
    @(posedge clk); #1;
    chk("c1_ready_back", 32'(bus.chr_ready), 1);
    chk("c1_col",        32'(cursor_col), 1);
    chk("c1_wen_off",    32'(bus.vram_w_en), 0);

    // table of single characters, applied cumulatively
    do_reset();
    for (int i = 0; i < 15; i++) begin
      wq.delete();
      send(vt[i].ch);
      wait_ready(20, $sformatf("v%0d_ready", i));
      chk($sformatf("v%0d_row", i), 32'(cursor_row), 32'(vt[i].row));
      chk($sformatf("v%0d_col", i), 32'(cursor_col), 32'(vt[i].col));
      chk($sformatf("v%0d_nw", i), wq.size(), vt[i].nw);
      if (vt[i].nw > 0 && wq.size() > 0) begin
        chk($sformatf("v%0d_addr", i), 32'(wq[0].a), 32'(vt[i].addr));
        chk($sformatf("v%0d_din", i), 32'(wq[0].d), 32'(vt[i].din));
      end
    end

    // full row of printables wraps to next row without scroll
    do_reset();
    for (int i = 0; i < 40; i++) send(8'h41);
    wait_ready(20, "row_ready");
    chk("row_nw", wq.size(), 40);
    bad = 0;
    foreach (wq[k])
      if (wq[k].a != 11'(k) || wq[k].d != 6'h01) bad++;
    chk("row_addrs", bad, 0);
    chk("row_row",   32'(cursor_row), 1);
    chk("row_col",   32'(cursor_col), 0);
    chk("row_start", 32'(start_row), 0);

    // 24 CRs reach the bottom and scroll one row
    do_reset();
    for (int i = 0; i < 24; i++) send(8'h0D);
    wait_ready(100, "scr_ready");
    chk("scr_start", 32'(start_row), 1);
    chk("scr_row",   32'(cursor_row), 24);
    chk("scr_nw",    wq.size(), 40);
    bad = 0;
    foreach (wq[k])
      if (wq[k].a != 11'(12'h600 + k) || wq[k].d != 6'd32) bad++;
    chk("scr_addrs", bad, 0);

    // clear requested mid-scroll runs after the sweep completes
    do_reset();
    for (int i = 0; i < 23; i++) send(8'h0D);
    wait_ready(20, "pre_scr_ready");
    wq.delete();
    send(8'h0D);
    @(posedge clk); #1;
    chk("mid_scr_wen", 32'(bus.vram_w_en), 1);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    wait_ready(3000, "clr_ready");
    chk("clr_nw", wq.size(), 2088);
    if (wq.size() == 2088) begin
      chk("clr_scr_last", 32'(wq[39].a), 32'h627);
      chk("clr_first",    32'(wq[40].a), 0);
      chk("clr_last",     32'(wq[2087].a), 32'h7FF);
    end
    bad = 0;
    foreach (wq[k]) if (wq[k].d != 6'd32) bad++;
    chk("clr_din", bad, 0);
    chk("clr_row",   32'(cursor_row), 0);
    chk("clr_col",   32'(cursor_col), 0);
    chk("clr_start", 32'(start_row), 0);
    chk("clr_busy",  32'(busy), 0);

    // clear wins over a character; reset aborts the clear sweep
    do_reset();
    send(8'hC1);
    wait_ready(20, "pre_clr_ready");
    clr_req       = 1'b1;
    bus.chr_valid = 1'b1;
    bus.chr_data  = 8'h42;
    #1;
    chk("clr_blocks_ready", 32'(bus.chr_ready), 0);
    @(posedge clk); #1;
    clr_req       = 1'b0;
    bus.chr_valid = 1'b0;
    chk("clr_col0",  32'(cursor_col), 0);
    chk("clr_busy1", 32'(busy), 1);
    chk("clr_wen1",  32'(bus.vram_w_en), 1);
    chk("clr_a0",    32'(bus.vram_w_addr), 0);
    chk("clr_d0",    32'(bus.vram_din), 32);
    repeat (100) @(posedge clk);
    #1;
    chk("clr_mid_wen",  32'(bus.vram_w_en), 1);
    chk("clr_mid_addr", 32'(bus.vram_w_addr), 100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_wen",   32'(bus.vram_w_en), 0);
    chk("abort_addr",  32'(bus.vram_w_addr), 0);
    chk("abort_din",   32'(bus.vram_din), 0);
    chk("abort_busy",  32'(busy), 0);
    chk("abort_ready", 32'(bus.chr_ready), 0);
    chk("abort_row",   32'(cursor_row), 0);
    chk("abort_col",   32'(cursor_col), 0);
    chk("abort_start", 32'(start_row), 0);
    n = wq.size();
    repeat (5) @(posedge clk);
    #1;
    chk("abort_nowrite", wq.size(), n);
    rst_n = 1'b1;
    #1;
    chk("abort_ready_back", 32'(bus.chr_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
